// File: rtl/rop_req_sched.sv
// rop_req_sched
// Round-robin request scheduler in front of the ROP datapath. It accepts one
// multi-lane fragment quad at a time from NUM_REQS core-side ports and
// serializes its active lanes into single-pixel beats, one per cycle, lowest
// lane first.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   req_valid   [R]         per-port request valid
//   req_tmask   [R*L]       active lane mask (port p, lane l at bit p*L+l)
//   req_pos_x/y [R*L*DIM]   lane coordinates
//   req_color   [R*L*32]    lane RGBA8888
//   req_depth   [R*L*DEP]   lane depth
//   req_backface[R*L]       lane backface flag
//   req_ready   [R]         one-hot accept strobe
//   pix_valid/pix_ready     pixel beat handshake
//   pix_pos_x/y, pix_color, pix_depth, pix_backface   pixel data
//   pix_src                 originating port index
//   pix_last                final active lane of the current request
//   busy                    a request is held
//
// Optional feature: define ROP_SCHED_PERF_EN to add perf_pixels (pixel
// handshakes) and perf_stalls (cycles with pix_valid && !pix_ready).
`timescale 1ns/1ps
module rop_req_sched #(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned DIM_BITS   = 12,
  parameter int unsigned DEPTH_BITS = 24,
  localparam int unsigned SRC_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_REQS-1:0]                  req_valid,
  input  logic [NUM_REQS*NUM_LANES-1:0]        req_tmask,
  input  logic [NUM_REQS*NUM_LANES*DIM_BITS-1:0]   req_pos_x,
  input  logic [NUM_REQS*NUM_LANES*DIM_BITS-1:0]   req_pos_y,
  input  logic [NUM_REQS*NUM_LANES*32-1:0]         req_color,
  input  logic [NUM_REQS*NUM_LANES*DEPTH_BITS-1:0] req_depth,
  input  logic [NUM_REQS*NUM_LANES-1:0]        req_backface,
  output logic [NUM_REQS-1:0]                  req_ready,
  output logic                                 pix_valid,
  input  logic                                 pix_ready,
  output logic [DIM_BITS-1:0]                  pix_pos_x,
  output logic [DIM_BITS-1:0]                  pix_pos_y,
  output logic [31:0]                          pix_color,
  output logic [DEPTH_BITS-1:0]                pix_depth,
  output logic                                 pix_backface,
  output logic [SRC_BITS-1:0]                  pix_src,
  output logic                                 pix_last,
  output logic                                 busy
`ifdef ROP_SCHED_PERF_EN
  ,
  output logic [31:0]                          perf_pixels,
  output logic [31:0]                          perf_stalls
`endif
);

  localparam int unsigned LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                            state_q, state_d;
  logic [NUM_LANES*DIM_BITS-1:0]     ent_x_q, ent_x_d;
  logic [NUM_LANES*DIM_BITS-1:0]     ent_y_q, ent_y_d;
  logic [NUM_LANES*32-1:0]           ent_c_q, ent_c_d;
  logic [NUM_LANES*DEPTH_BITS-1:0]   ent_z_q, ent_z_d;
  logic [NUM_LANES-1:0]              ent_bf_q, ent_bf_d;
  logic [NUM_LANES-1:0]              rem_q, rem_d;
  logic [SRC_BITS-1:0]               src_q, src_d;
  logic [SRC_BITS-1:0]               rr_q, rr_d;

  logic [NUM_LANES-1:0]              lane_oh;
  logic [LANE_BITS-1:0]              lane_sel;
  logic                              gnt_found;
  logic [SRC_BITS-1:0]               gnt_idx;
  logic                              fire;
  logic                              window;
  logic                              accept;

  // Lowest remaining lane: isolate the lowest set bit, then encode it.
  assign lane_oh = rem_q & (~rem_q + NUM_LANES'(1));

  always_comb begin
    lane_sel = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (lane_oh[l]) lane_sel = LANE_BITS'(l);
    end
  end

  // Round-robin scan starting at rr_q, wrapping modulo NUM_REQS.
  always_comb begin
    int unsigned scan;
    scan      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      scan = 32'(rr_q) + k;
      if (scan >= NUM_REQS) scan = scan - NUM_REQS;
      if (!gnt_found && req_valid[SRC_BITS'(scan)]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_BITS'(scan);
      end
    end
  end

  assign pix_valid    = (state_q == ISSUE);
  assign busy         = (state_q == ISSUE);
  assign pix_last     = (state_q == ISSUE) && $onehot(rem_q);
  assign pix_src      = src_q;
  assign pix_pos_x    = ent_x_q[lane_sel*DIM_BITS +: DIM_BITS];
  assign pix_pos_y    = ent_y_q[lane_sel*DIM_BITS +: DIM_BITS];
  assign pix_color    = ent_c_q[lane_sel*32 +: 32];
  assign pix_depth    = ent_z_q[lane_sel*DEPTH_BITS +: DEPTH_BITS];
  assign pix_backface = ent_bf_q[lane_sel];

  assign fire   = pix_valid && pix_ready;
  // A new request may be taken while idle or in the same cycle the final
  // beat of the held request hands off, giving bubble-free back-to-back.
  assign window = (state_q == IDLE) || (fire && pix_last);
  assign accept = window && gnt_found && reset_n;

  assign req_ready = accept ? (NUM_REQS'(1) << gnt_idx) : '0;

  always_comb begin
    state_d  = state_q;
    ent_x_d  = ent_x_q;
    ent_y_d  = ent_y_q;
    ent_c_d  = ent_c_q;
    ent_z_d  = ent_z_q;
    ent_bf_d = ent_bf_q;
    rem_d    = rem_q;
    src_d    = src_q;
    rr_d     = rr_q;

    if (fire) begin
      rem_d = rem_q & ~lane_oh;
      if (pix_last) state_d = IDLE;
    end

    if (accept) begin
      ent_x_d  = req_pos_x[gnt_idx*NUM_LANES*DIM_BITS +: NUM_LANES*DIM_BITS];
      ent_y_d  = req_pos_y[gnt_idx*NUM_LANES*DIM_BITS +: NUM_LANES*DIM_BITS];
      ent_c_d  = req_color[gnt_idx*NUM_LANES*32 +: NUM_LANES*32];
      ent_z_d  = req_depth[gnt_idx*NUM_LANES*DEPTH_BITS +: NUM_LANES*DEPTH_BITS];
      ent_bf_d = req_backface[gnt_idx*NUM_LANES +: NUM_LANES];
      rem_d    = req_tmask[gnt_idx*NUM_LANES +: NUM_LANES];
      src_d    = gnt_idx;
      rr_d     = (gnt_idx == SRC_BITS'(NUM_REQS-1)) ? '0 : gnt_idx + 1'b1;
      // An empty mask consumes the request without producing any beat.
      state_d  = (req_tmask[gnt_idx*NUM_LANES +: NUM_LANES] != '0) ? ISSUE : IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ent_x_q  <= '0;
      ent_y_q  <= '0;
      ent_c_q  <= '0;
      ent_z_q  <= '0;
      ent_bf_q <= '0;
      rem_q    <= '0;
      src_q    <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      ent_x_q  <= ent_x_d;
      ent_y_q  <= ent_y_d;
      ent_c_q  <= ent_c_d;
      ent_z_q  <= ent_z_d;
      ent_bf_q <= ent_bf_d;
      rem_q    <= rem_d;
      src_q    <= src_d;
      rr_q     <= rr_d;
    end
  end

`ifdef ROP_SCHED_PERF_EN
  logic [31:0] perf_pix_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_pix_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fire)                    perf_pix_q   <= perf_pix_q + 32'd1;
      if (pix_valid && !pix_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_pixels = perf_pix_q;
  assign perf_stalls = perf_stall_q;
`endif

endmodule

// File: tb/tb_rop_req_sched.sv
`timescale 1ns/1ps
module tb_rop_req_sched;
  localparam int N  = 4;
  localparam int L  = 4;
  localparam int D  = 12;
  localparam int Z  = 24;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid, req_ready;
  logic [N*L-1:0]   req_tmask, req_backface;
  logic [N*L*D-1:0] req_pos_x, req_pos_y;
  logic [N*L*32-1:0] req_color;
  logic [N*L*Z-1:0] req_depth;
  logic             pix_valid, pix_ready, pix_backface, pix_last, busy;
  logic [D-1:0]     pix_pos_x, pix_pos_y;
  logic [31:0]      pix_color;
  logic [Z-1:0]     pix_depth;
  logic [SB-1:0]    pix_src;
`ifdef ROP_SCHED_PERF_EN
  logic [31:0]      perf_pixels, perf_stalls;
`endif

  // Per-port stimulus, packed onto the flat DUT buses below.
  logic         t_valid[N];
  logic [L-1:0] t_mask[N];
  logic [D-1:0] t_x[N][L];
  logic [D-1:0] t_y[N][L];
  logic [31:0]  t_c[N][L];
  logic [Z-1:0] t_z[N][L];
  logic         t_bf[N][L];

  for (genvar p = 0; p < N; p++) begin : g_p
    assign req_valid[p]        = t_valid[p];
    assign req_tmask[p*L +: L] = t_mask[p];
    for (genvar l = 0; l < L; l++) begin : g_l
      assign req_pos_x[(p*L+l)*D +: D]   = t_x[p][l];
      assign req_pos_y[(p*L+l)*D +: D]   = t_y[p][l];
      assign req_color[(p*L+l)*32 +: 32] = t_c[p][l];
      assign req_depth[(p*L+l)*Z +: Z]   = t_z[p][l];
      assign req_backface[p*L+l]         = t_bf[p][l];
    end
  end

  rop_req_sched #(
    .NUM_REQS  (N),
    .NUM_LANES (L),
    .DIM_BITS  (D),
    .DEPTH_BITS(Z)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_tmask   (req_tmask),
    .req_pos_x   (req_pos_x),
    .req_pos_y   (req_pos_y),
    .req_color   (req_color),
    .req_depth   (req_depth),
    .req_backface(req_backface),
    .req_ready   (req_ready),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_pos_x   (pix_pos_x),
    .pix_pos_y   (pix_pos_y),
    .pix_color   (pix_color),
    .pix_depth   (pix_depth),
    .pix_backface(pix_backface),
    .pix_src     (pix_src),
    .pix_last    (pix_last),
    .busy        (busy)
`ifdef ROP_SCHED_PERF_EN
    ,
    .perf_pixels (perf_pixels),
    .perf_stalls (perf_stalls)
`endif
  );

  // Reference model: a queue of the pixel beats still owed, plus the
  // round-robin pointer and perf counts.
  typedef struct {
    logic [D-1:0] x;
    logic [D-1:0] y;
    logic [31:0]  c;
    logic [Z-1:0] z;
    logic         bf;
    int           src;
    bit           last;
  } beat_t;

  beat_t       mq[$];
  int          rr = 0;
  logic [31:0] m_pix = '0;
  logic [31:0] m_stall = '0;
  int          tests = 0;
  int          fails = 0;

  logic [N-1:0] exp_rdy = '0;
  logic [N-1:0] cap_rdy;
  logic         cap_pv, cap_last, cap_busy;
  logic [31:0]  cap_c;
  logic [SB-1:0] cap_src;
  logic [D-1:0] cap_x;
  logic [Z-1:0] cap_z;
  logic [31:0]  cap_stalls;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int grant_of();
    for (int k = 0; k < N; k++) begin
      int idx = (rr + k) % N;
      if (t_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: compare DUT to model mid-cycle, then advance the model.
  task automatic cycle();
    int g;
    bit win;
    @(negedge clk);
    #1;
    if (!reset_n) begin
      mq.delete();
      rr = 0;
      m_pix = '0;
      m_stall = '0;
    end
    g   = grant_of();
    win = (mq.size() == 0) || (pix_ready && mq.size() == 1);
    exp_rdy = '0;
    if (reset_n && win && g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("pix_valid", pix_valid, mq.size() != 0);
    chk("busy", busy, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("pix_pos_x", pix_pos_x, mq[0].x);
      chk("pix_pos_y", pix_pos_y, mq[0].y);
      chk("pix_color", pix_color, mq[0].c);
      chk("pix_depth", pix_depth, mq[0].z);
      chk("pix_backface", pix_backface, mq[0].bf);
      chk("pix_src", pix_src, mq[0].src);
      chk("pix_last", pix_last, mq[0].last);
    end else begin
      chk("pix_last_idle", pix_last, 1'b0);
    end
`ifdef ROP_SCHED_PERF_EN
    chk("perf_pixels", perf_pixels, m_pix);
    chk("perf_stalls", perf_stalls, m_stall);
    cap_stalls = perf_stalls;
`else
    cap_stalls = '0;
`endif
    cap_rdy  = req_ready;
    cap_pv   = pix_valid;
    cap_last = pix_last;
    cap_busy = busy;
    cap_c    = pix_color;
    cap_src  = pix_src;
    cap_x    = pix_pos_x;
    cap_z    = pix_depth;
    @(posedge clk);
    if (reset_n) begin
      if (mq.size() != 0) begin
        if (pix_ready) begin
          void'(mq.pop_front());
          m_pix++;
        end else begin
          m_stall++;
        end
      end
      if (exp_rdy != '0) begin
        int hi = -1;
        for (int l = 0; l < L; l++) if (t_mask[g][l]) hi = l;
        for (int l = 0; l < L; l++) begin
          if (t_mask[g][l]) begin
            beat_t b;
            b.x = t_x[g][l]; b.y = t_y[g][l]; b.c = t_c[g][l];
            b.z = t_z[g][l]; b.bf = t_bf[g][l]; b.src = g; b.last = (l == hi);
            mq.push_back(b);
          end
        end
        rr = (g + 1) % N;
      end
    end
    #1;
  endtask

  task automatic set_req(input int p, input logic [L-1:0] m, input logic [31:0] cbase);
    t_valid[p] = 1'b1;
    t_mask[p]  = m;
    for (int l = 0; l < L; l++) begin
      t_x[p][l]  = D'(p*16 + l + 1);
      t_y[p][l]  = D'(200 + l);
      t_c[p][l]  = cbase + 32'(l);
      t_z[p][l]  = Z'(p*4096 + l*7 + 3);
      t_bf[p][l] = (l % 2 == 1);
    end
  endtask

  task automatic rand_req(input int p);
    t_valid[p] = 1'b1;
    t_mask[p]  = ($urandom_range(0, 7) == 0) ? '0 : L'($urandom);
    for (int l = 0; l < L; l++) begin
      t_x[p][l]  = D'($urandom);
      t_y[p][l]  = D'($urandom);
      t_c[p][l]  = $urandom;
      t_z[p][l]  = Z'($urandom);
      t_bf[p][l] = 1'($urandom);
    end
  endtask

  task automatic clr();
    for (int p = 0; p < N; p++) t_valid[p] = 1'b0;
  endtask

  initial begin
    logic [31:0] s0;
    s0 = '0;
    pix_ready = 1'b1;
    for (int p = 0; p < N; p++) set_req(p, '0, '0);
    clr();

    // Reset values, with a request pending to show req_ready is held low.
    set_req(0, 4'hF, 32'h11);
    cycle();
    chk("rst_req_ready", cap_rdy, 4'b0000);
    chk("rst_pix_valid", cap_pv, 1'b0);
    chk("rst_pix_last", cap_last, 1'b0);
    chk("rst_busy", cap_busy, 1'b0);
    chk("rst_pix_src", cap_src, 2'd0);
    chk("rst_pix_color", cap_c, 32'd0);
    chk("rst_pix_x", cap_x, 12'd0);
    chk("rst_pix_depth", cap_z, 24'd0);
    cycle();
    clr();
    reset_n = 1'b1;
    cycle();

    // Single port, mask 1011: beats A0, A1, A3.
    set_req(0, 4'b1011, 32'hA0);
    cycle();
    chk("t2_accept", cap_rdy, 4'b0001);
    clr();
    cycle();
    chk("t2_b0_color", cap_c, 32'hA0);
    chk("t2_b0_last", cap_last, 1'b0);
    chk("t2_b0_src", cap_src, 2'd0);
    cycle();
    chk("t2_b1_color", cap_c, 32'hA1);
    chk("t2_b1_last", cap_last, 1'b0);
    cycle();
    chk("t2_b2_color", cap_c, 32'hA3);
    chk("t2_b2_last", cap_last, 1'b1);
    cycle();
    chk("t2_busy_after", cap_busy, 1'b0);
    chk("t2_pv_after", cap_pv, 1'b0);

    // Ports 1 and 3 alternate with no idle cycle.
    set_req(1, 4'b0001, 32'hC0);
    set_req(3, 4'b0001, 32'hD0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t3_grant", cap_rdy, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      if (i > 0) begin
        chk("t3_pv", cap_pv, 1'b1);
        chk("t3_src", cap_src, (i % 2 == 0) ? 2'd3 : 2'd1);
      end
    end
    clr();
    cycle();
    chk("t3_drain_src", cap_src, 2'd3);
    cycle();

    // Empty mask on port 2: consumed, no beat, pointer moves to 3.
    set_req(2, 4'b0000, 32'h0);
    cycle();
    chk("t4_zero_ready", cap_rdy, 4'b0100);
    clr();
    cycle();
    chk("t4_no_beat", cap_pv, 1'b0);
    set_req(0, 4'b0001, 32'hE0);
    set_req(3, 4'b0001, 32'hF0);
    cycle();
    chk("t4_rr_to_3", cap_rdy, 4'b1000);
    clr();
    cycle();
    cycle();

    // Stall for 5 cycles mid-request, then hand off to waiting port 2.
    set_req(0, 4'b1111, 32'hB0);
    cycle();
    chk("t5_accept", cap_rdy, 4'b0001);
    clr();
    cycle();
    chk("t5_b0", cap_c, 32'hB0);
    pix_ready = 1'b0;
    set_req(2, 4'b0011, 32'h50);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) s0 = cap_stalls;
      chk("t5_stall_color", cap_c, 32'hB1);
      chk("t5_stall_ready", cap_rdy, 4'b0000);
    end
    pix_ready = 1'b1;
    cycle();
    chk("t5_b1", cap_c, 32'hB1);
`ifdef ROP_SCHED_PERF_EN
    chk("t5_perf_stalls", cap_stalls - s0, 32'd5);
`endif
    cycle();
    chk("t5_b2", cap_c, 32'hB2);
    cycle();
    chk("t5_b3_last", cap_last, 1'b1);
    chk("t5_handoff", cap_rdy, 4'b0100);
    clr();
    cycle();
    chk("t5_p2_first", cap_c, 32'h50);
    chk("t5_p2_src", cap_src, 2'd2);
    cycle();
    chk("t5_p2_last", cap_last, 1'b1);
    cycle();

    // Reset during ISSUE with 2 lanes remaining.
    set_req(1, 4'b1111, 32'h70);
    cycle();
    chk("t6_accept", cap_rdy, 4'b0010);
    clr();
    cycle();
    cycle();
    reset_n = 1'b0;
    cycle();
    chk("t6_rst_pv", cap_pv, 1'b0);
    chk("t6_rst_busy", cap_busy, 1'b0);
    reset_n = 1'b1;
    for (int p = 0; p < N; p++) set_req(p, 4'b0001, 32'h90);
    cycle();
    chk("t6_port0_first", cap_rdy, 4'b0001);
    clr();

    // Randomized traffic; requesters hold valid and data until accepted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (t_valid[p]) begin
          if (exp_rdy[p]) begin
            if ($urandom_range(0, 1) == 1) rand_req(p);
            else t_valid[p] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rand_req(p);
        end
      end
      pix_ready = ($urandom_range(0, 3) != 0);
      reset_n   = ($urandom_range(0, 599) != 0);
      cycle();
    end
    clr();
    reset_n   = 1'b1;
    pix_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
